// File: rtl/echo_request_input.sv
// Request-side demarshaller for the echo portal: parses header+payload words and queues say values.
// Optional error counter (err_count port) is built when ECHO_REQ_ERR_COUNT_EN is defined.
module echo_request_input #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        RDY_requests_0_enq,
  input  logic        EN_requests_0_enq,
  input  logic [31:0] requests_0_enq_v,
  output logic        RDY_requests_0_notFull,
  output logic        requests_0_notFull,
  output logic        RDY_messageSize_size,
  input  logic [15:0] messageSize_size_methodNumber,
  output logic [15:0] messageSize_size,
  input  logic        RDY_request_say,
  output logic        EN_request_say,
  output logic [31:0] request_say_v
`ifdef ECHO_REQ_ERR_COUNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    PAYLOAD = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;

  logic            fifo_full, fifo_empty;
  logic            enq_fire, push, pop;
  logic [15:0]     hdr_method, hdr_len;

  assign hdr_method = requests_0_enq_v[31:16];
  assign hdr_len    = requests_0_enq_v[15:0];

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);

  // Only a pending payload word can be stalled; headers and discards always flow.
  assign RDY_requests_0_enq     = !((state_q == PAYLOAD) && fifo_full);
  assign requests_0_notFull     = RDY_requests_0_enq;
  assign RDY_requests_0_notFull = 1'b1;
  assign RDY_messageSize_size   = 1'b1;
  assign messageSize_size       = (messageSize_size_methodNumber == 16'd0) ? 16'd32 : 16'd0;

  assign enq_fire       = EN_requests_0_enq && RDY_requests_0_enq;
  assign pop            = !fifo_empty && RDY_request_say;
  assign EN_request_say = pop;
  assign request_say_v  = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= HEADER;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (enq_fire) begin
      case (state_q)
        HEADER: begin
          if (hdr_len == 16'd0) begin
            state_d = HEADER;
          end else if ((hdr_method == 16'd0) && (hdr_len == 16'd1)) begin
            state_d = PAYLOAD;
          end else begin
            cnt_d   = hdr_len;
            state_d = DISCARD;
          end
        end
        PAYLOAD: begin
          push    = 1'b1;
          state_d = HEADER;
        end
        DISCARD: begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = HEADER;
        end
        default: state_d = HEADER;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to 0 while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= requests_0_enq_v;
  end

`ifdef ECHO_REQ_ERR_COUNT_EN
  logic        err_hdr;
  logic [15:0] err_q, err_d;

  // Every header except method 0 with one payload word is an error.
  assign err_hdr = enq_fire && (state_q == HEADER) &&
                   !((hdr_method == 16'd0) && (hdr_len == 16'd1));

  always_comb begin
    err_d = err_q;
    if (err_hdr && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_echo_request_input.sv
// Directed self-checking bench for echo_request_input (DEPTH=4).
// Error-counter checks are compiled only with ECHO_REQ_ERR_COUNT_EN.
module tb_echo_request_input;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        RDY_requests_0_enq;
  logic        EN_requests_0_enq = 1'b0;
  logic [31:0] requests_0_enq_v = '0;
  logic        RDY_requests_0_notFull;
  logic        requests_0_notFull;
  logic        RDY_messageSize_size;
  logic [15:0] messageSize_size_methodNumber = '0;
  logic [15:0] messageSize_size;
  logic        RDY_request_say = 1'b0;
  logic        EN_request_say;
  logic [31:0] request_say_v;
`ifdef ECHO_REQ_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  echo_request_input #(.DEPTH(4)) dut (
    .CLK                           (CLK),
    .RST_N                         (RST_N),
    .RDY_requests_0_enq            (RDY_requests_0_enq),
    .EN_requests_0_enq             (EN_requests_0_enq),
    .requests_0_enq_v              (requests_0_enq_v),
    .RDY_requests_0_notFull        (RDY_requests_0_notFull),
    .requests_0_notFull            (requests_0_notFull),
    .RDY_messageSize_size          (RDY_messageSize_size),
    .messageSize_size_methodNumber (messageSize_size_methodNumber),
    .messageSize_size              (messageSize_size),
    .RDY_request_say               (RDY_request_say),
    .EN_request_say                (EN_request_say),
    .request_say_v                 (request_say_v)
`ifdef ECHO_REQ_ERR_COUNT_EN
    ,
    .err_count                     (err_count)
`endif
  );

  // Inputs change on the falling edge; every task starts and ends just after a falling edge.
  task automatic do_reset();
    EN_requests_0_enq = 1'b0;
    RST_N = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic enq_word(input logic [31:0] w);
    int n = 0;
    while (!RDY_requests_0_enq && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!RDY_requests_0_enq) begin
      tests++; fails++;
      $display("FAIL enq_ready_timeout: got rdy=%0b required 1", RDY_requests_0_enq);
    end else begin
      EN_requests_0_enq = 1'b1;
      requests_0_enq_v  = w;
      @(negedge CLK);
      EN_requests_0_enq = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (EN_request_say !== 1'b0) begin fails++; $display("FAIL reset_en_say: got %0b required 0", EN_request_say); end
    tests++; if (request_say_v !== 32'd0) begin fails++; $display("FAIL reset_say_v: got %0h required 0", request_say_v); end
    tests++; if (RDY_requests_0_enq !== 1'b1) begin fails++; $display("FAIL reset_rdy_enq: got %0b required 1", RDY_requests_0_enq); end
    tests++; if (requests_0_notFull !== 1'b1) begin fails++; $display("FAIL reset_notfull: got %0b required 1", requests_0_notFull); end
    tests++; if (RDY_requests_0_notFull !== 1'b1 || RDY_messageSize_size !== 1'b1) begin
      fails++; $display("FAIL reset_const_rdy: got %0b/%0b required 1/1", RDY_requests_0_notFull, RDY_messageSize_size);
    end
`ifdef ECHO_REQ_ERR_COUNT_EN
    tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL reset_err_count: got %0h required 0", err_count); end
`endif
  endtask

  task automatic test_single_say();
    do_reset();
    RDY_request_say = 1'b1;
    enq_word(32'h0000_0001);
    tests++; if (EN_request_say !== 1'b0) begin fails++; $display("FAIL single_early_en: got %0b required 0", EN_request_say); end
    enq_word(32'hDEAD_BEEF);
    tests++; if (EN_request_say !== 1'b1 || request_say_v !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL single_deliver: got en=%0b v=%0h required en=1 v=deadbeef", EN_request_say, request_say_v);
    end
    @(negedge CLK);
    tests++; if (EN_request_say !== 1'b0 || request_say_v !== 32'd0) begin
      fails++; $display("FAIL single_once: got en=%0b v=%0h required en=0 v=0", EN_request_say, request_say_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v;
    do_reset();
    RDY_request_say = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      enq_word(32'h0000_0001);
      enq_word(32'(i));
    end
    tests++; if (RDY_requests_0_enq !== 1'b1) begin fails++; $display("FAIL b2b_hdr_rdy_full: got %0b required 1", RDY_requests_0_enq); end
    enq_word(32'h0000_0001);
    tests++; if (RDY_requests_0_enq !== 1'b0 || requests_0_notFull !== 1'b0) begin
      fails++; $display("FAIL b2b_backpressure: got rdy=%0b nf=%0b required 0/0", RDY_requests_0_enq, requests_0_notFull);
    end
    @(negedge CLK);
    tests++; if (RDY_requests_0_enq !== 1'b0) begin fails++; $display("FAIL b2b_hold: got %0b required 0", RDY_requests_0_enq); end
    RDY_request_say = 1'b1;
    #1;
    tests++; if (EN_request_say !== 1'b1 || request_say_v !== 32'd1 || RDY_requests_0_enq !== 1'b0) begin
      fails++; $display("FAIL b2b_first_pop: got en=%0b v=%0h rdy=%0b required 1/1/0", EN_request_say, request_say_v, RDY_requests_0_enq);
    end
    @(negedge CLK);
    tests++; if (RDY_requests_0_enq !== 1'b1 || request_say_v !== 32'd2) begin
      fails++; $display("FAIL b2b_rdy_after_pop: got rdy=%0b v=%0h required 1/2", RDY_requests_0_enq, request_say_v);
    end
    enq_word(32'd5);
    for (int k = 3; k <= 5; k++) begin
      exp_v = 32'(k);
      tests++; if (EN_request_say !== 1'b1 || request_say_v !== exp_v) begin
        fails++; $display("FAIL b2b_order: got en=%0b v=%0h required en=1 v=%0h", EN_request_say, request_say_v, exp_v);
      end
      @(negedge CLK);
    end
    tests++; if (EN_request_say !== 1'b0) begin fails++; $display("FAIL b2b_drained: got %0b required 0", EN_request_say); end
  endtask

  task automatic test_discard();
    do_reset();
    RDY_request_say = 1'b1;
    enq_word(32'h0003_0002);
    enq_word(32'hAAAA_0001);
    enq_word(32'hAAAA_0002);
    enq_word(32'h0005_0001);
    enq_word(32'hBBBB_0001);
    enq_word(32'h0000_0002);
    enq_word(32'hCCCC_0001);
    enq_word(32'hCCCC_0002);
    tests++; if (EN_request_say !== 1'b0) begin fails++; $display("FAIL discard_leak: got en=%0b v=%0h required en=0", EN_request_say, request_say_v); end
    enq_word(32'h0000_0001);
    enq_word(32'h1234_5678);
    tests++; if (EN_request_say !== 1'b1 || request_say_v !== 32'h1234_5678) begin
      fails++; $display("FAIL discard_then_say: got en=%0b v=%0h required en=1 v=12345678", EN_request_say, request_say_v);
    end
    @(negedge CLK);
    tests++; if (EN_request_say !== 1'b0) begin fails++; $display("FAIL discard_single: got %0b required 0", EN_request_say); end
`ifdef ECHO_REQ_ERR_COUNT_EN
    tests++; if (err_count !== 16'd3) begin fails++; $display("FAIL discard_err_count: got %0h required 3", err_count); end
`endif
  endtask

  task automatic test_len_zero();
    do_reset();
    RDY_request_say = 1'b1;
    enq_word(32'h0000_0000);
    enq_word(32'h0000_0001);
    enq_word(32'd7);
    tests++; if (EN_request_say !== 1'b1 || request_say_v !== 32'd7) begin
      fails++; $display("FAIL len0_then_say: got en=%0b v=%0h required en=1 v=7", EN_request_say, request_say_v);
    end
`ifdef ECHO_REQ_ERR_COUNT_EN
    tests++; if (err_count !== 16'd1) begin fails++; $display("FAIL len0_err_count: got %0h required 1", err_count); end
    EN_requests_0_enq = 1'b1;
    requests_0_enq_v  = 32'h0001_0000;
    repeat (65533) @(negedge CLK);
    tests++; if (err_count !== 16'hFFFE) begin fails++; $display("FAIL err_near_sat: got %0h required fffe", err_count); end
    @(negedge CLK);
    tests++; if (err_count !== 16'hFFFF) begin fails++; $display("FAIL err_at_sat: got %0h required ffff", err_count); end
    repeat (3) @(negedge CLK);
    EN_requests_0_enq = 1'b0;
    tests++; if (err_count !== 16'hFFFF) begin fails++; $display("FAIL err_saturate: got %0h required ffff", err_count); end
`endif
  endtask

  task automatic test_reset_mid_message();
    do_reset();
    RDY_request_say = 1'b0;
    enq_word(32'h0000_0001);
    enq_word(32'h0000_000A);
    enq_word(32'h0000_0001);
    enq_word(32'h0000_000B);
    enq_word(32'h0000_0001);
    RDY_request_say = 1'b1;
    #1;
    tests++; if (EN_request_say !== 1'b1 || request_say_v !== 32'h0000_000A) begin
      fails++; $display("FAIL mid_pre_reset: got en=%0b v=%0h required en=1 v=a", EN_request_say, request_say_v);
    end
    #1 RST_N = 1'b0;
    #1;
    tests++; if (EN_request_say !== 1'b0 || request_say_v !== 32'd0 || RDY_requests_0_enq !== 1'b1) begin
      fails++; $display("FAIL mid_async_reset: got en=%0b v=%0h rdy=%0b required 0/0/1", EN_request_say, request_say_v, RDY_requests_0_enq);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    enq_word(32'h0000_0001);
    tests++; if (EN_request_say !== 1'b0) begin fails++; $display("FAIL mid_stale_data: got en=%0b v=%0h required en=0", EN_request_say, request_say_v); end
    enq_word(32'd9);
    tests++; if (EN_request_say !== 1'b1 || request_say_v !== 32'd9) begin
      fails++; $display("FAIL mid_fresh_say: got en=%0b v=%0h required en=1 v=9", EN_request_say, request_say_v);
    end
    @(negedge CLK);
    tests++; if (EN_request_say !== 1'b0) begin fails++; $display("FAIL mid_only_one: got %0b required 0", EN_request_say); end
  endtask

  task automatic test_message_size();
    messageSize_size_methodNumber = 16'd0;
    #1;
    tests++; if (messageSize_size !== 16'd32) begin fails++; $display("FAIL msgsize_m0: got %0d required 32", messageSize_size); end
    messageSize_size_methodNumber = 16'd5;
    #1;
    tests++; if (messageSize_size !== 16'd0) begin fails++; $display("FAIL msgsize_m5: got %0d required 0", messageSize_size); end
    messageSize_size_methodNumber = 16'hFFFF;
    #1;
    tests++; if (messageSize_size !== 16'd0) begin fails++; $display("FAIL msgsize_mffff: got %0d required 0", messageSize_size); end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_single_say();
    test_back_to_back();
    test_discard();
    test_len_zero();
    test_reset_mid_message();
    test_message_size();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
